// File: rtl/dfs_result_buffer.sv
// rtl/dfs_result_buffer.sv - captures DFS best vectors as 8-PAM amplitudes into a tagged FWFT FIFO
//
// Purpose:
//   Samples the four 3-bit best-symbol indices on each InReady completion pulse.
//   Each index is converted to a signed 8-PAM amplitude (2*idx-7). The result is
//   tagged with a sequence number and queued in a first-word-fall-through FIFO.
//   The consumer pops entries with a valid/accept handshake.
//
// Ports:
//   Clk            rising-edge clock
//   Reset          asynchronous active-low reset
//   InReady        one-cycle completion pulse from the DFS detector
//   InData0..3_best  best symbol index per level (3 bits)
//   OutAccept      consumer ready; pops the head when OutValid is high
//   ClearOverflow  clears the sticky Overflow flag
//   OutValid       head entry valid (Count != 0)
//   OutSym0..3     signed 4-bit amplitude of head entry (0 when not valid)
//   OutSeq         sequence tag of head entry (0 when not valid)
//   Count          number of entries held, 0..DEPTH
//   Overflow       sticky flag, set when a result had to be dropped

module dfs_result_buffer #(
    parameter int DEPTH = 4,
    parameter int SEQ_W = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     InReady,
    input  logic [2:0]               InData0_best,
    input  logic [2:0]               InData1_best,
    input  logic [2:0]               InData2_best,
    input  logic [2:0]               InData3_best,
    input  logic                     OutAccept,
    input  logic                     ClearOverflow,
    output logic                     OutValid,
    output logic [3:0]               OutSym0,
    output logic [3:0]               OutSym1,
    output logic [3:0]               OutSym2,
    output logic [3:0]               OutSym3,
    output logic [SEQ_W-1:0]         OutSeq,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [15:0]      sym_mem [DEPTH];
    logic [SEQ_W-1:0] seq_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [SEQ_W-1:0] seq_q;
    logic             overflow_q;

    logic             full;
    logic             push;
    logic             pop;
    logic [15:0]      in_syms;
    logic [15:0]      head_syms;

    // 2*idx - 7 in 4-bit two's complement; the doubled index never exceeds 14,
    // so the modulo-16 subtraction gives the exact amplitude without saturation.
    function automatic logic [3:0] to_amp(input logic [2:0] idx);
        return {idx, 1'b0} - 4'd7;
    endfunction

    assign in_syms = {to_amp(InData3_best), to_amp(InData2_best),
                      to_amp(InData1_best), to_amp(InData0_best)};

    assign full = (count_q == FULL_CNT);
    assign pop  = OutValid && OutAccept;
    // A pop frees the slot in the same edge, so a full FIFO can still take a new result.
    assign push = InReady && (!full || pop);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // Every completion consumes a tag, even a dropped one, so gaps in
            // OutSeq reveal exactly how many results were lost.
            if (InReady) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            // Set has priority over clear.
            if (InReady && !push) begin
                overflow_q <= 1'b1;
            end else if (ClearOverflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge Clk) begin
        if (push) begin
            sym_mem[wr_ptr] <= in_syms;
            seq_mem[wr_ptr] <= seq_q;
        end
    end

    assign head_syms = sym_mem[rd_ptr];

    assign OutValid = (count_q != '0);
    assign OutSym0  = OutValid ? head_syms[3:0]   : 4'd0;
    assign OutSym1  = OutValid ? head_syms[7:4]   : 4'd0;
    assign OutSym2  = OutValid ? head_syms[11:8]  : 4'd0;
    assign OutSym3  = OutValid ? head_syms[15:12] : 4'd0;
    assign OutSeq   = OutValid ? seq_mem[rd_ptr]  : '0;
    assign Count    = count_q;
    assign Overflow = overflow_q;

endmodule
